// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Constants shared by the execute-stage multiply sequencer and the decoder:
//   - FSM state encoding for the multiply sequencer (IDLE / RUN / FINISH)
//   - ALU_MULT, the ALUControl code the decoder issues for mult/multu
//   - WIDTH_DEFAULT, the datapath width of the pipeline
// No ports; import with "import mips_pkg::*;".
// -----------------------------------------------------------------------------
package mips_pkg;

  localparam int WIDTH_DEFAULT = 32;

  // ALUControl code for mult/multu; execute raises StartE when it sees this.
  localparam logic [3:0] ALU_MULT = 4'b1000;

  // Multiply sequencer state encoding.
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

endpackage

// File: rtl/mult_sequencer_if.sv
// -----------------------------------------------------------------------------
// mult_sequencer_if
// Bundle between the execute stage / hazard unit and the multiply sequencer.
//   StartE     : execute-stage instruction is a multiply
//   SignedE    : 1 = mult (two's complement), 0 = multu
//   SrcAE/SrcBE: multiplicand / multiplier
//   StallMultE : freeze PC, IF/ID and ID/EX while the multiply owns E
//   BusyE      : sequencer not idle
//   DoneW      : one-cycle pulse, HI/LO just updated
//   HI/LO      : upper / lower product words
// Modports: master = pipeline side, slave = sequencer side.
// -----------------------------------------------------------------------------
interface mult_sequencer_if
  import mips_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
);

  logic             StartE;
  logic             SignedE;
  logic [WIDTH-1:0] SrcAE;
  logic [WIDTH-1:0] SrcBE;
  logic             StallMultE;
  logic             BusyE;
  logic             DoneW;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (
    output StartE, SignedE, SrcAE, SrcBE,
    input  StallMultE, BusyE, DoneW, HI, LO
  );

  modport slave (
    input  StartE, SignedE, SrcAE, SrcBE,
    output StallMultE, BusyE, DoneW, HI, LO
  );

endinterface

// File: rtl/mult_step.sv
// -----------------------------------------------------------------------------
// mult_step
// One combinational shift-add iteration of the unsigned multiplier.
//   i_acc_hi (WIDTH+1) : upper accumulator (partial product)
//   i_acc_lo (WIDTH)   : lower accumulator (remaining multiplier bits /
//                        low product bits shifted in)
//   i_mcand  (WIDTH)   : multiplicand magnitude
//   o_acc_hi, o_acc_lo : accumulators after one add-and-shift-right
// -----------------------------------------------------------------------------
module mult_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   i_acc_hi,
  input  logic [WIDTH-1:0] i_acc_lo,
  input  logic [WIDTH-1:0] i_mcand,
  output logic [WIDTH:0]   o_acc_hi,
  output logic [WIDTH-1:0] o_acc_lo
);

  logic [WIDTH:0] w_addend;
  logic [WIDTH:0] w_sum;

  // The multiplier LSB sits at acc_lo[0] and selects whether to add mcand.
  assign w_addend = i_acc_lo[0] ? {1'b0, i_mcand} : '0;

  // acc_hi stays below 2^WIDTH between steps, so WIDTH+1 bits hold the sum.
  assign w_sum = i_acc_hi + w_addend;

  // {acc_hi, acc_lo} <= {sum, acc_lo} >> 1
  assign o_acc_hi = {1'b0, w_sum[WIDTH:1]};
  assign o_acc_lo = {w_sum[0], i_acc_lo[WIDTH-1:1]};

endmodule

// File: rtl/mult_sequencer.sv
// -----------------------------------------------------------------------------
// mult_sequencer
// Iterative shift-add multiplier for the execute stage. Accepts a mult/multu
// on StartE, stalls F/D/E via StallMultE, runs WIDTH add-shift steps on the
// operand magnitudes, applies the sign in FINISH and loads HI/LO.
// One multiply occupies E for WIDTH+2 cycles (1 IDLE + WIDTH RUN + 1 FINISH).
// Ports:
//   clk   : pipeline clock, rising edge
//   reset : synchronous, active-high; aborts any operation
//   bus   : mult_sequencer_if slave (StartE, SignedE, SrcAE, SrcBE in;
//           StallMultE, BusyE, DoneW, HI, LO out)
// -----------------------------------------------------------------------------
module mult_sequencer
  import mips_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic           clk,
  input  logic           reset,
  mult_sequencer_if.slave bus
);

  logic [1:0]         r_state;
  logic [CNT_W-1:0]   r_count;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH:0]     r_acc_hi;
  logic [WIDTH-1:0]   r_acc_lo;
  logic               r_neg;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;
  logic               r_busy;

  logic               w_neg_a;
  logic               w_neg_b;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH:0]     w_step_hi;
  logic [WIDTH-1:0]   w_step_lo;
  logic [2*WIDTH-1:0] w_mag;
  logic [2*WIDTH-1:0] w_prod;
  logic               w_last_step;

  // Magnitudes: only mult (SignedE=1) treats the MSB as a sign. The most
  // negative value negates to itself, which is its correct unsigned magnitude.
  assign w_neg_a = bus.SignedE & bus.SrcAE[WIDTH-1];
  assign w_neg_b = bus.SignedE & bus.SrcBE[WIDTH-1];
  assign w_abs_a = w_neg_a ? (~bus.SrcAE + WIDTH'(1)) : bus.SrcAE;
  assign w_abs_b = w_neg_b ? (~bus.SrcBE + WIDTH'(1)) : bus.SrcBE;

  mult_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_acc_hi (r_acc_hi),
    .i_acc_lo (r_acc_lo),
    .i_mcand  (r_mcand),
    .o_acc_hi (w_step_hi),
    .o_acc_lo (w_step_lo)
  );

  assign w_last_step = (r_count == CNT_W'(WIDTH - 1));

  // After WIDTH steps acc_hi[WIDTH] is always zero; drop it for the product.
  assign w_mag  = {r_acc_hi[WIDTH-1:0], r_acc_lo};
  assign w_prod = r_neg ? (~w_mag + (2*WIDTH)'(1)) : w_mag;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_mcand  <= '0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_neg    <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.StartE) begin
            r_mcand  <= w_abs_a;
            r_acc_lo <= w_abs_b;
            r_acc_hi <= '0;
            r_neg    <= w_neg_a ^ w_neg_b;
            r_count  <= '0;
            r_state  <= S_RUN;
            r_busy   <= 1'b1;
          end
        end
        S_RUN: begin
          r_acc_hi <= w_step_hi;
          r_acc_lo <= w_step_lo;
          r_count  <= r_count + CNT_W'(1);
          if (w_last_step) begin
            r_state <= S_FINISH;
          end
        end
        S_FINISH: begin
          // StartE here belongs to the instruction that is finishing; ignore it.
          r_hi    <= w_prod[2*WIDTH-1:WIDTH];
          r_lo    <= w_prod[WIDTH-1:0];
          r_done  <= 1'b1;
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Combinational so the accept cycle itself already freezes the front end.
  // Low in FINISH: the multiply leaves E on the FINISH edge.
  assign bus.StallMultE = ((r_state == S_IDLE) & bus.StartE) | (r_state == S_RUN);
  assign bus.BusyE      = r_busy;
  assign bus.DoneW      = r_done;
  assign bus.HI         = r_hi;
  assign bus.LO         = r_lo;

endmodule

// File: tb/tb_mult_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mult_sequencer
// Drives mult/multu instructions the way the execute stage would (instruction
// held in E while StallMultE is high, advancing on the edge after it drops),
// pushes the reference product to a queue at issue, and compares HI/LO when
// DoneW pulses.
// -----------------------------------------------------------------------------
module tb_mult_sequencer;

  localparam int WIDTH = 32;

  logic clk;
  logic reset;

  mult_sequencer_if #(.WIDTH(WIDTH)) bus ();

  mult_sequencer #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    if (s) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      return sa * sb;
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  // Holds one multiply in E until the sequencer releases the stall, then
  // advances on the following edge. Optionally scribbles on the operand
  // inputs mid-RUN to show they were captured at accept.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s, input bit toggle);
    int  stall_cnt = 0;
    bit  fin = 0;
    bus.StartE  = 1'b1;
    bus.SignedE = s;
    bus.SrcAE   = a;
    bus.SrcBE   = b;
    exp_q.push_back(model(a, b, s));
    $display("issue %s 0x%h x 0x%h toggle=%0d", s ? "mult " : "multu", a, b, toggle);
    for (int cyc = 0; cyc < 100 && !fin; cyc++) begin
      @(negedge clk);
      if (cyc == 0) check("busy_at_accept", {63'b0, bus.BusyE}, 64'd0);
      if (bus.StallMultE) begin
        stall_cnt++;
      end else begin
        fin = 1;
        check("busy_at_finish", {63'b0, bus.BusyE}, 64'd1);
      end
      if (toggle && cyc == 10) begin
        bus.SrcAE = ~a;
        bus.SrcBE = a ^ b;
      end
    end
    check("stall_cycles", 64'(stall_cnt), 64'(WIDTH + 1));
    check("finish_seen", {63'b0, fin}, 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.StartE = 1'b0;
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  // Completion monitor: one scoreboard pop per DoneW pulse.
  initial begin
    logic [63:0] e;
    bit prev_fin;
    prev_fin = 0;
    forever begin
      @(negedge clk);
      if (bus.DoneW === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("done_unexpected", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          $display("done HI=0x%h LO=0x%h expected 0x%h", bus.HI, bus.LO, e);
          check("HI", {32'b0, bus.HI}, {32'b0, e[63:32]});
          check("LO", {32'b0, bus.LO}, {32'b0, e[31:0]});
          check("done_after_finish", {63'b0, prev_fin}, 64'd1);
        end
      end
      prev_fin = (bus.BusyE === 1'b1) && (bus.StallMultE === 1'b0);
    end
  end

  initial begin
    reset       = 1'b1;
    bus.StartE  = 1'b0;
    bus.SignedE = 1'b0;
    bus.SrcAE   = '0;
    bus.SrcBE   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_stall", {63'b0, bus.StallMultE}, 64'd0);
    check("rst_busy",  {63'b0, bus.BusyE}, 64'd0);
    check("rst_done",  {63'b0, bus.DoneW}, 64'd0);
    check("rst_hi",    {32'b0, bus.HI}, 64'd0);
    check("rst_lo",    {32'b0, bus.LO}, 64'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    issue(32'd6, 32'd7, 1'b0, 0);
    idle(2);
    issue(32'hFFFF_FFFD, 32'd5, 1'b1, 0);
    idle(1);
    issue(32'h8000_0000, 32'h8000_0000, 1'b1, 0);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
    idle(2);

    // Back-to-back with operand inputs disturbed mid-RUN.
    issue(32'd2, 32'd3, 1'b0, 1);
    issue(32'd4, 32'd5, 1'b0, 1);
    idle(2);

    // Zero operand still takes the full latency.
    issue(32'd0, 32'h1234_5678, 1'b1, 0);
    idle(2);

    // Abort at RUN count=10: accept negedge, then RUN negedges count 0..10.
    bus.StartE  = 1'b1;
    bus.SignedE = 1'b0;
    bus.SrcAE   = 32'd9;
    bus.SrcBE   = 32'd9;
    $display("issue multu 0x00000009 x 0x00000009 aborted by reset");
    repeat (12) @(negedge clk);
    reset      = 1'b1;
    bus.StartE = 1'b0;
    @(posedge clk);
    #1;
    check("abort_stall", {63'b0, bus.StallMultE}, 64'd0);
    check("abort_busy",  {63'b0, bus.BusyE}, 64'd0);
    check("abort_done",  {63'b0, bus.DoneW}, 64'd0);
    check("abort_hi",    {32'b0, bus.HI}, 64'd0);
    check("abort_lo",    {32'b0, bus.LO}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    idle(40);

    // Randomised back-to-back run.
    for (int i = 0; i < 6; i++) begin
      issue($urandom, $urandom, 1'($urandom_range(0, 1)), (i % 2) == 1);
    end
    idle(1);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mult_sequencer.md
Name: mult_sequencer

Overview:
Iterative shift-add multiply controller for the 5-stage MIPS pipeline.
- Decode issues ALUControl code 4'b1000 for mult/multu. In execute, this block takes that instruction and stalls F/D/E through the hazard unit.
- It produces the 64-bit product over WIDTH+2 cycles, then loads the HI/LO registers.
- Its purpose is to keep a 32x32 combinational multiplier out of the ALU critical path.

Parameters:
- WIDTH, 32, operand width; the product is 2*WIDTH bits.
- CNT_W, $clog2(WIDTH)+1, iteration counter width.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk.
- StartE  in  1  execute-stage instruction is a multiply (ALUControlE == 4'b1000).
- SignedE  in  1  1 = mult (two's complement), 0 = multu; sampled with StartE.
- SrcAE  in  WIDTH  multiplicand, sampled on the accept edge.
- SrcBE  in  WIDTH  multiplier, sampled on the accept edge.
- StallMultE  out  1  combinational; to the hazard unit to freeze PC, IF/ID and ID/EX.
- BusyE  out  1  registered; high when state != IDLE.
- DoneW  out  1  registered; one-cycle pulse, HI/LO just updated.
- HI  out  WIDTH  upper product word (read by mfhi).
- LO  out  WIDTH  lower product word (read by mflo).

Behaviour:
- Reset values: state=IDLE, count=0, HI=0, LO=0, DoneW=0, BusyE=0, internal accumulators=0.
- Reset in any state aborts the operation: next cycle is IDLE, StallMultE=0, HI/LO=0.

States: IDLE, RUN, FINISH.
- IDLE:
  - With StartE=1 (the accept edge), latch:
    - mcand = |SrcAE|, plier = |SrcBE|;
    - neg = SignedE & (SrcAE[W-1] ^ SrcBE[W-1]);
    - acc_hi = 0 (WIDTH+1 bits), acc_lo = plier, count = 0.
  - Go to RUN.
  - Absolute value applies only when SignedE=1.
  - 0x80000000 has magnitude 2^31, which fits unsigned in WIDTH.
- RUN, per cycle:
  - sum = acc_hi + (acc_lo[0] ? mcand : 0), WIDTH+1 bits.
  - {acc_hi, acc_lo} <= {sum, acc_lo} >> 1.
  - count++.
  - When count == WIDTH-1 (the WIDTH-th step), go to FINISH.
- FINISH:
  - prod = {acc_hi[W-1:0], acc_lo}; if neg, prod = ~prod + 1 (2*WIDTH-bit wrap).
  - {HI, LO} <= prod; DoneW <= 1; go to IDLE.

StallMultE = (state==IDLE & StartE) | (state==RUN).
- It is low in FINISH, so the multiply leaves E on the FINISH edge.
- StartE, still high during FINISH for the same instruction, is ignored.

Latency and timing:
- One multiply occupies E for exactly WIDTH+2 cycles: 1 IDLE + WIDTH RUN + 1 FINISH.
- HI/LO are valid from the cycle after FINISH, in which DoneW=1.
- Back-to-back multiplies: StallMultE is high WIDTH+1 cycles, low 1 cycle (FINISH), then high again.

Boundary and update rules:
- StartE while not IDLE: ignored.
- Operands are captured only on the accept edge; later changes on SrcAE/SrcBE have no effect.
- HI/LO are never partially updated; they hold their old value until the FINISH edge.
- Zero operand: runs the full WIDTH+2 cycles, with no early exit.

Decomposition:
- Shared package (mips_pkg):
  - state encoding (IDLE=2'd0, RUN=2'd1, FINISH=2'd2);
  - ALU_MULT = 4'b1000, shared with the decoder's ALUControl codes;
  - WIDTH default.
- Sub-module mult_step: combinational one-iteration shift-add, inputs acc_hi, acc_lo, mcand; outputs next acc_hi, acc_lo.
- The FSM, counter, sign handling and HI/LO registers stay in mult_sequencer.

Test Plan:
- multu 6 x 7: StartE=1, SignedE=0 -> StallMultE high 33 cycles; DoneW at cycle 34; HI=0x00000000, LO=0x0000002A.
- mult -3 x 5 (0xFFFFFFFD, 0x00000005) -> HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- mult 0x80000000 x 0x80000000 -> HI=0x40000000, LO=0x00000000. multu 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- Reset asserted at RUN count=10 -> next cycle state=IDLE, StallMultE=0, BusyE=0, HI=LO=0; DoneW never pulses.
- Two consecutive multiplies (2x3 then 4x5): stall pattern 33 high / 1 low / 33 high. After the first DoneW, LO=6; after the second, LO=20. SrcAE toggled mid-RUN does not change the result.
